// File: rtl/gun_controller.sv
// ---------------------------------------------------------------------------
// gun_controller
//   Player-ship stage that feeds the laser block. It conditions the three
//   raw buttons (2-FF synchroniser plus debounce counter), moves the ship
//   horizontally on game ticks, raises a fire request that is held until
//   the laser block samples it on a tick, and then enforces a cooldown
//   measured in ticks. It also renders the ship pixel colour for the mixer.
//
// Ports
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-low reset
//   enable       in   1   one-clk game tick, shared with the laser block
//   btnLeft      in   1   raw button, 1 = pressed
//   btnRight     in   1   raw button, 1 = pressed
//   btnFire      in   1   raw button, 1 = pressed
//   gameOver     in   1   freezes the ship and kills any pending shot
//   hPos         in   10  current pixel x
//   vPos         in   10  current pixel y
//   gunPosition  out  10  ship centre x (registered)
//   fire         out  1   shot request to the laser block (registered)
//   colorGun     out  3   ship pixel colour (registered)
// ---------------------------------------------------------------------------
module gun_controller #(
    parameter int SCREEN_WIDTH    = 640,
    parameter int SCREEN_HEIGHT   = 480,
    parameter int SHIP_WIDTH      = 60,
    parameter int SHIP_HEIGHT     = 30,
    parameter int V_OFFSET        = 10,
    parameter int STEP_MOTION     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int COOLDOWN_TICKS  = 30,
    parameter int BACKGROUND      = 0,
    parameter int GUN             = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic       btnFire,
    input  logic       gameOver,
    input  logic [9:0] hPos,
    input  logic [9:0] vPos,
    output logic [9:0] gunPosition,
    output logic       fire,
    output logic [2:0] colorGun
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int CD_W = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(COOLDOWN_TICKS);
    localparam logic [9:0]      HALF_W    = 10'(SHIP_WIDTH / 2);
    localparam logic [9:0]      POS_MIN   = 10'(SHIP_WIDTH / 2);
    localparam logic [9:0]      POS_MAX   = 10'(SCREEN_WIDTH - SHIP_WIDTH / 2 - 1);
    localparam logic [9:0]      POS_RESET = 10'(SCREEN_WIDTH / 2 - 1);
    localparam logic [9:0]      STEP      = 10'(STEP_MOTION);
    localparam logic [9:0]      Y_TOP     = 10'(SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT);
    localparam logic [9:0]      Y_BOT     = 10'(SCREEN_HEIGHT - V_OFFSET - 1);
    localparam logic [2:0]      COL_GUN   = 3'(GUN);
    localparam logic [2:0]      COL_BG    = 3'(BACKGROUND);

    // Button bit order everywhere: [0] left, [1] right, [2] fire.
    localparam int B_LEFT  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_FIRE  = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_COOLDOWN
    } state_t;

    logic [2:0]            btn_raw;
    logic [2:0]            sync1_q, sync1_d;
    logic [2:0]            sync2_q, sync2_d;
    logic [2:0]            stable_q, stable_d;
    logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic                  fire_prev_q, fire_prev_d;
    logic                  fire_rise;
    logic [9:0]            pos_q, pos_d;
    state_t                state_q, state_d;
    logic [CD_W-1:0]       cd_q, cd_d;
    logic                  fire_q, fire_d;
    logic [2:0]            color_q, color_d;
    logic [10:0]           x_lo, x_hi;
    logic                  in_x, in_y;

    assign btn_raw = {btnFire, btnRight, btnLeft};

    // ---------------- input conditioning ----------------
    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        stable_d    = stable_q;
        db_cnt_d    = '0;
        fire_prev_d = stable_q[B_FIRE];
        for (int i = 0; i < 3; i++) begin
            // Counter only runs while the synchronised level disagrees with
            // the accepted level; any agreement restarts the qualification.
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Edge is taken against a registered copy so a held button fires once.
    assign fire_rise = stable_q[B_FIRE] & ~fire_prev_q;

    // ---------------- ship motion ----------------
    always_comb begin
        pos_d = pos_q;
        if (enable && !gameOver) begin
            // Distances are compared before stepping so the 10-bit position
            // can never wrap past either edge.
            if (stable_q[B_LEFT] && !stable_q[B_RIGHT]) begin
                pos_d = ((pos_q - POS_MIN) < STEP) ? POS_MIN : pos_q - STEP;
            end else if (stable_q[B_RIGHT] && !stable_q[B_LEFT]) begin
                pos_d = ((POS_MAX - pos_q) < STEP) ? POS_MAX : pos_q + STEP;
            end
        end
    end

    // ---------------- fire FSM ----------------
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        if (gameOver) begin
            state_d = S_IDLE;
            cd_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fire_rise) begin
                        state_d = S_PENDING;
                    end
                end
                S_PENDING: begin
                    // The laser block samples fire on this same tick edge.
                    if (enable) begin
                        state_d = S_COOLDOWN;
                        cd_d    = CD_LOAD;
                    end
                end
                S_COOLDOWN: begin
                    // Edges arriving here (including on the final tick) are
                    // dropped because the IDLE branch is not evaluated.
                    if (enable) begin
                        if (cd_q <= CD_W'(1)) begin
                            cd_d    = '0;
                            state_d = S_IDLE;
                        end else begin
                            cd_d = cd_q - CD_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cd_d    = '0;
                end
            endcase
        end
        fire_d = (state_d == S_PENDING);
    end

    // ---------------- ship colour ----------------
    always_comb begin
        // 11-bit arithmetic keeps the left bound from underflowing.
        x_lo    = {1'b0, pos_q} - {1'b0, HALF_W};
        x_hi    = {1'b0, pos_q} + {1'b0, HALF_W} - 11'd1;
        in_x    = ({1'b0, hPos} >= x_lo) && ({1'b0, hPos} <= x_hi);
        in_y    = (vPos >= Y_TOP) && (vPos <= Y_BOT);
        color_d = (in_x && in_y) ? COL_GUN : COL_BG;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            db_cnt_q    <= '0;
            fire_prev_q <= 1'b0;
            pos_q       <= POS_RESET;
            state_q     <= S_IDLE;
            cd_q        <= '0;
            fire_q      <= 1'b0;
            color_q     <= COL_BG;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            stable_q    <= stable_d;
            db_cnt_q    <= db_cnt_d;
            fire_prev_q <= fire_prev_d;
            pos_q       <= pos_d;
            state_q     <= state_d;
            cd_q        <= cd_d;
            fire_q      <= fire_d;
            color_q     <= color_d;
        end
    end

    assign gunPosition = pos_q;
    assign fire        = fire_q;
    assign colorGun    = color_q;

endmodule

// File: tb/tb_gun_controller.sv
// ---------------------------------------------------------------------------
// tb_gun_controller
//   Directed stimulus with a behavioural reference model. The model tracks
//   raw-button history and accepts a level change once the last DEB
//   synchronised samples all disagree with the accepted level; ship motion,
//   shot request, cooldown and colour follow directly from the game rules.
//   A compare process checks every output on every falling edge out of
//   reset, and the stimulus adds hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_gun_controller;

    localparam int DEB    = 4;
    localparam int COOL   = 3;
    localparam int HIST   = DEB + 2;
    localparam int P_MIN  = 30;
    localparam int P_MAX  = 609;
    localparam int STEPPX = 2;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       btnLeft;
    logic       btnRight;
    logic       btnFire;
    logic       gameOver;
    logic [9:0] hPos;
    logic [9:0] vPos;
    logic [9:0] gunPosition;
    logic       fire;
    logic [2:0] colorGun;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int       m_pos;
    bit       m_pend;
    int       m_cd;
    bit [2:0] m_stb;
    bit       m_prev;
    int       m_color;
    int       hist [3][HIST];

    gun_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .COOLDOWN_TICKS (COOL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .btnLeft    (btnLeft),
        .btnRight   (btnRight),
        .btnFire    (btnFire),
        .gameOver   (gameOver),
        .hPos       (hPos),
        .vPos       (vPos),
        .gunPosition(gunPosition),
        .fire       (fire),
        .colorGun   (colorGun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    initial begin
        logic [2:0] raw;
        bit         rise;
        bit         all_diff;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_pos   = 319;
                m_pend  = 0;
                m_cd    = 0;
                m_stb   = '0;
                m_prev  = 0;
                m_color = 0;
                for (int b = 0; b < 3; b++)
                    for (int i = 0; i < HIST; i++) hist[b][i] = 0;
            end else begin
                raw = {btnFire, btnRight, btnLeft};
                for (int b = 0; b < 3; b++) begin
                    for (int i = HIST - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
                    hist[b][0] = int'(raw[b]);
                end
                // colour from the ship position held before this edge
                m_color = (int'(hPos) >= m_pos - 30 && int'(hPos) <= m_pos + 29 &&
                           int'(vPos) >= 440 && int'(vPos) <= 469) ? 2 : 0;
                // motion
                if (enable && !gameOver) begin
                    if (m_stb[0] && !m_stb[1])
                        m_pos = (m_pos - STEPPX < P_MIN) ? P_MIN : m_pos - STEPPX;
                    else if (m_stb[1] && !m_stb[0])
                        m_pos = (m_pos + STEPPX > P_MAX) ? P_MAX : m_pos + STEPPX;
                end
                // shot request
                rise = m_stb[2] && !m_prev;
                if (gameOver) begin
                    m_pend = 0;
                    m_cd   = 0;
                end else if (m_pend) begin
                    if (enable) begin
                        m_pend = 0;
                        m_cd   = COOL;
                    end
                end else if (m_cd > 0) begin
                    if (enable) m_cd--;
                end else if (rise) begin
                    m_pend = 1;
                end
                m_prev = m_stb[2];
                // debounce: synchronised sample is two edges old
                for (int b = 0; b < 3; b++) begin
                    all_diff = 1;
                    for (int i = 2; i < HIST; i++)
                        if (hist[b][i] == int'(m_stb[b])) all_diff = 0;
                    if (all_diff) m_stb[b] = ~m_stb[b];
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                check("model_pos",   int'(gunPosition), m_pos);
                check("model_fire",  int'(fire),        int'(m_pend));
                check("model_color", int'(colorGun),    m_color);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            enable = 1'b1;
            step(1);
            enable = 1'b0;
            step(1);
        end
    endtask

    initial begin
        reset    = 1'b0;
        enable   = 1'b0;
        btnLeft  = 1'b0;
        btnRight = 1'b0;
        btnFire  = 1'b0;
        gameOver = 1'b0;
        hPos     = '0;
        vPos     = '0;
        step(3);
        check("reset_pos",   int'(gunPosition), 319);
        check("reset_fire",  int'(fire),        0);
        check("reset_color", int'(colorGun),    0);
        reset = 1'b1;
        step(2);

        // colour window at the reset position
        vPos = 10'd440; hPos = 10'd289; step(2); check("color_left_edge",  int'(colorGun), 2);
        hPos = 10'd348;                 step(2); check("color_right_edge", int'(colorGun), 2);
        hPos = 10'd288;                 step(2); check("color_left_out",   int'(colorGun), 0);
        hPos = 10'd349;                 step(2); check("color_right_out",  int'(colorGun), 0);
        hPos = 10'd300; vPos = 10'd470; step(2); check("color_below",      int'(colorGun), 0);
        vPos = 10'd469;                 step(2); check("color_bottom_row", int'(colorGun), 2);
        hPos = '0; vPos = '0;
        step(1);

        // debounce: a 3-clk glitch is rejected
        btnLeft = 1'b1; step(3); btnLeft = 1'b0;
        step(10);
        tick(2);
        check("glitch_no_move", int'(gunPosition), 319);
        // held press moves 5 steps
        btnLeft = 1'b1; step(8);
        tick(5);
        check("left_5_ticks", int'(gunPosition), 309);
        btnLeft = 1'b0; step(8);

        // clamp at the right edge
        btnRight = 1'b1; step(8);
        tick(149);
        check("right_to_607", int'(gunPosition), 607);
        tick(1); check("right_to_609",  int'(gunPosition), 609);
        tick(1); check("right_clamped", int'(gunPosition), 609);
        btnRight = 1'b0; step(8);
        // clamp at the left edge
        btnLeft = 1'b1; step(8);
        tick(289);
        check("left_to_31", int'(gunPosition), 31);
        tick(1); check("left_to_30",   int'(gunPosition), 30);
        tick(1); check("left_clamped", int'(gunPosition), 30);
        btnRight = 1'b1; step(8);
        tick(2);
        check("both_hold", int'(gunPosition), 30);
        btnLeft = 1'b0; btnRight = 1'b0; step(8);

        // fire handshake timing
        btnFire = 1'b1;
        step(6); check("fire_before_7clk", int'(fire), 0);
        step(1); check("fire_at_7clk",     int'(fire), 1);
        step(3);
        enable = 1'b1;
        check("fire_during_enable", int'(fire), 1);
        step(1);
        enable = 1'b0;
        check("fire_after_enable", int'(fire), 0);
        step(1);
        tick(5);
        check("held_no_refire", int'(fire), 0);
        btnFire = 1'b0; step(8);

        // cooldown: re-press ignored, later press accepted
        btnFire = 1'b1; step(8);
        check("shot2_pending", int'(fire), 1);
        tick(1);
        btnFire = 1'b0; step(8);
        btnFire = 1'b1; step(8);
        check("cooldown_ignored", int'(fire), 0);
        btnFire = 1'b0; step(8);
        tick(3);
        btnFire = 1'b1; step(8);
        check("after_cooldown_fire", int'(fire), 1);
        tick(1);
        btnFire = 1'b0; step(8);
        tick(3);

        // gameOver kills a pending shot and freezes everything
        btnFire = 1'b1; step(8);
        check("go_pending", int'(fire), 1);
        gameOver = 1'b1;
        step(1);
        check("go_fire_drop", int'(fire), 0);
        btnFire = 1'b0; step(8);
        btnRight = 1'b1; step(8);
        tick(3);
        check("go_no_move", int'(gunPosition), 30);
        btnRight = 1'b0; step(8);
        btnFire = 1'b1; step(8);
        check("go_no_fire", int'(fire), 0);
        btnFire = 1'b0; step(8);
        gameOver = 1'b0;
        step(2);

        // asynchronous reset in the middle of a pending shot
        hPos = 10'd30; vPos = 10'd450;
        btnFire = 1'b1; step(8);
        check("pre_reset_fire",  int'(fire),     1);
        check("pre_reset_color", int'(colorGun), 2);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_fire",  int'(fire),        0);
        check("async_reset_pos",   int'(gunPosition), 319);
        check("async_reset_color", int'(colorGun),    0);
        btnFire = 1'b0;
        step(3);
        reset = 1'b1;
        step(10);
        tick(4);
        check("post_reset_fire", int'(fire),        0);
        check("post_reset_pos",  int'(gunPosition), 319);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "time limit");
    end

endmodule
